// File: rtl/nf2401_pkg.sv
// Shared definitions for the nRF2401 serial engine: register map, bit positions
// and the shifter state encoding.
package nf2401_pkg;

  localparam logic [1:0] ADDR_TX   = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVR  = 2;
  localparam int STAT_DR1  = 3;

  localparam int CTRL_MODE    = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_DIV_SEL = 7;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

endpackage

// File: rtl/nf2401_sync2.sv
// Two-flop synchronizer bringing the radio's asynchronous DR1 into the clk domain.
module nf2401_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nf2401_serial_engine.sv
// Avalon-MM byte shifter for the nRF2401 3-wire interface (CLK1, DATA, DR1).
// Shifts one byte MSB first; mode and divider are latched when a transfer starts.
module nf2401_serial_engine
  import nf2401_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic       read_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       irq,
  output logic       nf_clk1,
  inout  wire        nf_data,
  input  logic       nf_dr1
);

  state_t state, state_n;

  logic [DIV_W-1:0] div_q, div_lat, hp_cnt;
  logic             mode_q, irq_en_q, mode_lat;
  logic [7:0]       shift, rx_data;
  logic [2:0]       bit_cnt;
  logic             busy, done, overrun, dr1_sync;

  logic wr, rd, tx_wr, start, tc, shift_en, finish;

  assign wr    = chipselect && !write_n;
  assign rd    = chipselect && !read_n;
  assign tx_wr = wr && (address == ADDR_TX);
  assign start = tx_wr && (state == IDLE);
  assign tc    = (hp_cnt == div_lat);

  nf2401_sync2 u_sync_dr1 (
    .clk  (clk),
    .reset(reset),
    .d    (nf_dr1),
    .q    (dr1_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE:   if (start) state_n = LOW;
      LOW:    if (tc) state_n = HIGH;
      HIGH: begin
        if (tc) begin
          shift_en = 1'b1;
          state_n  = (bit_cnt == 3'd0) ? FINISH : LOW;
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hp_cnt   <= '0;
      shift    <= '0;
      rx_data  <= '0;
      bit_cnt  <= '0;
      mode_lat <= 1'b0;
      div_lat  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      hp_cnt <= ((state == LOW || state == HIGH) && !tc) ? hp_cnt + DIV_W'(1) : '0;

      if (start) begin
        shift    <= writedata;
        mode_lat <= mode_q;
        div_lat  <= div_q;
        bit_cnt  <= 3'd7;
      end else if (shift_en) begin
        // Receive samples DATA at the end of the high phase, just before CLK1 falls.
        shift   <= {shift[6:0], mode_lat ? nf_data : 1'b0};
        bit_cnt <= bit_cnt - 3'd1;
      end

      if (finish && mode_lat) rx_data <= shift;

      if (start)       busy <= 1'b1;
      else if (finish) busy <= 1'b0;

      if (finish)
        done <= 1'b1;
      else if (start || (rd && address == ADDR_RX) ||
               (wr && address == ADDR_STAT && writedata[STAT_DONE]))
        done <= 1'b0;

      if (tx_wr && state != IDLE)
        overrun <= 1'b1;
      else if (wr && address == ADDR_STAT && writedata[STAT_OVR])
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= DIV_W'(DIV_RESET);
      mode_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr && address == ADDR_CTRL) begin
      if (writedata[CTRL_DIV_SEL]) begin
        div_q <= DIV_W'(writedata[6:0]);
      end else begin
        mode_q   <= writedata[CTRL_MODE];
        irq_en_q <= writedata[CTRL_IRQ_EN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      irq <= done && irq_en_q;
      case (address)
        ADDR_RX:   readdata <= rx_data;
        ADDR_STAT: readdata <= {4'b0, dr1_sync, overrun, done, busy};
        ADDR_CTRL: readdata <= {6'b0, irq_en_q, mode_q};
        default:   readdata <= 8'h00;
      endcase
    end
  end

  assign nf_clk1 = (state == HIGH);
  assign nf_data = (busy && !mode_lat) ? shift[7] : 1'bz;

endmodule

// File: tb/tb_nf2401_serial_engine.sv
// Directed bench for nf2401_serial_engine: register table plus serial transfer sequences.
module tb_nf2401_serial_engine;
  import nf2401_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] address = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic       read_n = 1'b1;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       irq;
  logic       nf_clk1;
  wire        nf_data;
  logic       nf_dr1 = 1'b0;

  logic       drv_en = 1'b0;
  logic       drv_val = 1'b0;
  assign nf_data = drv_en ? drv_val : 1'bz;

  int errors = 0;
  int checks = 0;

  nf2401_serial_engine #(.DIV_W(8), .DIV_RESET(25)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .read_n    (read_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .nf_clk1   (nf_clk1),
    .nf_data   (nf_data),
    .nf_dr1    (nf_dr1)
  );

  always #5 clk = ~clk;

  // Radio model: captures transmitted bits and drives receive bits on CLK1 rising edges.
  logic       cap_en = 1'b0;
  logic [7:0] cap = 8'h00;
  int         ncap = 0;
  int         unstable = 0;
  logic       rx_en = 1'b0;
  logic [7:0] rx_pat = 8'h00;
  int         rx_idx = 0;

  always @(posedge nf_clk1) begin
    if (cap_en) begin
      cap  = {cap[6:0], nf_data};
      ncap = ncap + 1;
    end
    if (rx_en && rx_idx < 8) begin
      drv_val = rx_pat[7 - rx_idx];
      rx_idx  = rx_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (cap_en && nf_clk1 && nf_data !== cap[0]) unstable = unstable + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  // Line is released by the DUT when the bench can pull it both ways.
  task automatic check_z(input string name);
    drv_en = 1'b1; drv_val = 1'b0;
    #1 check({name, "_z0"}, {31'b0, nf_data}, 32'd0);
    drv_val = 1'b1;
    #1 check({name, "_z1"}, {31'b0, nf_data}, 32'd1);
    drv_en = 1'b0;
  endtask

  // Writes TXDATA, optionally a CONTROL write on the next cycle, then polls STATUS.done.
  // n = posedges from the one sampling the write (n=1) until readdata shows done.
  task automatic tx_and_wait(input logic [7:0] d, input bit mid_en, input logic [7:0] mid_d,
                             input int limit, output int n);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = ADDR_TX; writedata = d;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    if (mid_en) begin
      address = ADDR_CTRL; writedata = mid_d;
      @(posedge clk);
      n = 2;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STAT;
    while (n < limit) begin
      @(posedge clk);
      n++;
      #1;
      if (readdata[STAT_DONE]) break;
    end
  endtask

  typedef struct {
    bit         is_wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [7:0] rd;
    int n;

    vt[0] = '{1'b0, ADDR_STAT, 8'h00, 8'h00};
    vt[1] = '{1'b0, ADDR_CTRL, 8'h00, 8'h00};
    vt[2] = '{1'b0, ADDR_RX,   8'h00, 8'h00};
    vt[3] = '{1'b0, ADDR_TX,   8'h00, 8'h00};
    vt[4] = '{1'b1, ADDR_CTRL, 8'h03, 8'h00};
    vt[5] = '{1'b0, ADDR_CTRL, 8'h00, 8'h03};
    vt[6] = '{1'b1, ADDR_CTRL, 8'h83, 8'h00};
    vt[7] = '{1'b0, ADDR_CTRL, 8'h00, 8'h03};
    vt[8] = '{1'b1, ADDR_CTRL, 8'h00, 8'h00};
    vt[9] = '{1'b0, ADDR_CTRL, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_clk1", {31'b0, nf_clk1}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_readdata", {24'b0, readdata}, 32'd0);
    check_z("rst_data");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) bus_write(vt[i].a, vt[i].d);
      else begin
        bus_read(vt[i].a, rd);
        check($sformatf("vec%0d", i), {24'b0, rd}, {24'b0, vt[i].exp});
      end
    end
    // CONTROL bit 7 write only moved div (3); restore the reset divider for the timing check.
    bus_write(ADDR_CTRL, 8'h99);

    // Reset divider 25: 16*26+2 = 418 cycles to done, +1 for registered read.
    // div=0 written during the transfer must not affect it.
    cap = 8'h00; ncap = 0; unstable = 0; cap_en = 1'b1;
    tx_and_wait(8'h5A, 1'b1, 8'h80, 600, n);
    check("div25_latency", n, 419);
    check("div25_bits", {24'b0, cap}, 32'h5A);
    check("div25_nbits", ncap, 8);
    @(negedge clk);
    check_z("div25_idle");

    // div=1, 0xA5: done 34 cycles after the write.
    bus_write(ADDR_CTRL, 8'h81);
    cap = 8'h00; ncap = 0; unstable = 0;
    tx_and_wait(8'hA5, 1'b0, 8'h00, 100, n);
    check("tx_latency", n, 35);
    check("tx_bits", {24'b0, cap}, 32'hA5);
    check("tx_nbits", ncap, 8);
    check("tx_stable", unstable, 0);
    check("tx_status", {24'b0, readdata}, 32'h02);
    cap_en = 1'b0;

    // Receive 0x3C at div=0.
    bus_write(ADDR_CTRL, 8'h80);
    bus_write(ADDR_CTRL, 8'h01);
    rx_pat = 8'h3C; rx_idx = 0; drv_val = 1'b0; drv_en = 1'b1; rx_en = 1'b1;
    tx_and_wait(8'h00, 1'b0, 8'h00, 60, n);
    check("rx_latency", n, 19);
    rx_en = 1'b0; drv_en = 1'b0;
    bus_read(ADDR_RX, rd);
    check("rx_data", {24'b0, rd}, 32'h3C);
    bus_read(ADDR_STAT, rd);
    check("rx_done_cleared", {24'b0, rd}, 32'h00);

    // Overrun: back-to-back TXDATA writes, only the first byte goes out.
    bus_write(ADDR_CTRL, 8'h00);
    cap = 8'h00; ncap = 0; cap_en = 1'b1;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = ADDR_TX; writedata = 8'h81;
    @(negedge clk);
    writedata = 8'h7E;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (30) @(negedge clk);
    cap_en = 1'b0;
    check("ovr_bits", {24'b0, cap}, 32'h81);
    check("ovr_nbits", ncap, 8);
    bus_read(ADDR_STAT, rd);
    check("ovr_status", {24'b0, rd}, 32'h06);
    bus_write(ADDR_STAT, 8'h04);
    bus_read(ADDR_STAT, rd);
    check("ovr_w1c", {24'b0, rd}, 32'h02);

    // Interrupt on completion, cleared through done W1C.
    bus_write(ADDR_CTRL, 8'h02);
    @(negedge clk);
    check("irq_pending_done", {31'b0, irq}, 32'd1);
    bus_write(ADDR_STAT, 8'h02);
    bus_read(ADDR_STAT, rd);
    check("irq_done_w1c", {24'b0, rd}, 32'h00);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    tx_and_wait(8'h11, 1'b0, 8'h00, 60, n);
    check("irq_latency", n, 19);
    @(negedge clk);
    check("irq_set", {31'b0, irq}, 32'd1);
    bus_write(ADDR_STAT, 8'h02);
    check("irq_held_one_cycle", {31'b0, irq}, 32'd1);
    @(negedge clk);
    check("irq_drop", {31'b0, irq}, 32'd0);

    // Reset after 3 bits while CLK1 is high.
    bus_write(ADDR_CTRL, 8'h00);
    bus_write(ADDR_CTRL, 8'h81);
    cap = 8'h00; ncap = 0; cap_en = 1'b1;
    bus_write(ADDR_TX, 8'hFF);
    n = 0;
    while (ncap < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_bit3", ncap, 3);
    check("mid_clk1_high", {31'b0, nf_clk1}, 32'd1);
    reset = 1'b1;
    #1 check("mid_rst_clk1", {31'b0, nf_clk1}, 32'd0);
    check_z("mid_rst_data");
    cap_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_read(ADDR_STAT, rd);
    check("mid_rst_status", {24'b0, rd}, 32'h00);
    bus_read(ADDR_RX, rd);
    check("mid_rst_rx", {24'b0, rd}, 32'h00);
    repeat (40) @(negedge clk);
    check("mid_rst_no_clk", ncap, 3);

    // DR1: two synchronizer flops then the registered read.
    address = ADDR_STAT;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      nf_dr1 = (k == 0);
      n = 0;
      while (n < 10) begin
        @(posedge clk);
        n++;
        #1;
        if (readdata[STAT_DR1] == (k == 0)) break;
      end
      check($sformatf("dr1_delay%0d", k), n, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
